// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter.
// UART_ARB_TAG_EN adds the TAG state and the tag byte base.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
`ifdef UART_ARB_TAG_EN
    TAG       = 3'd1,
`endif
    LOAD      = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } arb_state_t;

`ifdef UART_ARB_TAG_EN
  localparam logic [7:0] TAG_BASE = 8'h30;
`endif

  function automatic int baud_cnt_w(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Client byte-stream bus: per-client valid/data/last with ready back.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Free-running baud enable: one registered pulse every CLK_DIV clocks.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 3
) (
  input  logic clk,
  input  logic rst,
  output logic baud_en
);

  localparam int W = baud_cnt_w(CLK_DIV);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      baud_en <= 1'b0;
    end else if (cnt == W'(CLK_DIV - 1)) begin
      cnt     <= '0;
      baud_en <= 1'b1;
    end else begin
      cnt     <= cnt + W'(1);
      baud_en <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between N_REQ byte-stream clients.
// UART_ARB_TAG_EN prefixes each burst with a TAG_BASE+index frame.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int CLK_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave req,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             baud_en,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_ready
);

  localparam int IW = $clog2(N_REQ);

  typedef logic [IW-1:0] idx_t;

  arb_state_t       state_q;
  arb_state_t       state_d;
  idx_t             rr_q;
  idx_t             rr_d;
  idx_t             owner_q;
  idx_t             owner_d;
  idx_t             pick;
  logic [N_REQ-1:0] grant_d;
  logic [7:0]       data_d;
  logic             start_d;
  logic             last_q;
  logic             last_d;
  logic             sel_valid;
  logic             sel_last;
  logic [7:0]       sel_data;
  logic             fire;

  // First requester strictly after the previous owner, wrapping.
  function automatic idx_t rr_pick(
    input logic [N_REQ-1:0] v,
    input idx_t             p
  );
    idx_t w;
    w = p;
    for (int k = N_REQ; k >= 1; k--) begin
      int c;
      c = (int'(p) + k) % N_REQ;
      if (v[idx_t'(c)]) w = idx_t'(c);
    end
    return w;
  endfunction

  uart_baud_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .baud_en(baud_en)
  );

  assign pick      = rr_pick(req.req_valid, rr_q);
  assign sel_valid = req.req_valid[owner_q];
  assign sel_last  = req.req_last[owner_q];
  assign sel_data  = req.req_data[{owner_q, 3'b000} +: 8];

  assign req.req_ready =
    (!rst && state_q == LOAD && tx_ready) ? grant : '0;

  assign fire = !rst && state_q == LOAD
             && tx_ready && sel_valid;

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    grant_d = grant;
    data_d  = tx_data;
    start_d = 1'b0;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (|req.req_valid) begin
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
`ifdef UART_ARB_TAG_EN
          state_d       = TAG;
`else
          state_d       = LOAD;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      TAG: begin
        if (tx_ready) begin
          data_d  = TAG_BASE + 8'(owner_q);
          start_d = 1'b1;
          state_d = WAIT_BUSY;
        end
      end
`endif
      LOAD: begin
        if (fire) begin
          data_d  = sel_data;
          last_d  = sel_last;
          start_d = 1'b1;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!tx_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          if (last_q) begin
            state_d = IDLE;
            rr_d    = owner_q;
            grant_d = '0;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= idx_t'(N_REQ - 1);
      owner_q  <= '0;
      grant    <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      grant    <= grant_d;
      tx_data  <= data_d;
      tx_start <= start_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int DIV = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] grant;
  logic         busy;
  logic         baud_en;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         tx_ready;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(
    .N_REQ  (N),
    .CLK_DIV(DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (bus),
    .grant   (grant),
    .busy    (busy),
    .baud_en (baud_en),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [8:0] cq[N][$];
  logic [7:0] expq[$];
  logic [9:0] frames[$];
  int         vprob = 100;
  bit         mon_en = 1'b0;
  int         last_owner = N - 1;
  int         nstart = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp_v, $time);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++)
      if (cq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // uart_tx stand-in: 10-bit frame, one bit per baud_en, then ready.
  logic       u_rdy;
  logic [9:0] u_sh;
  logic [9:0] u_rx;
  int         u_n;
  assign tx_ready = u_rdy;

  always @(posedge clk) begin
    if (rst) begin
      u_rdy <= 1'b1;
      u_n   <= 0;
    end else if (u_rdy) begin
      if (tx_start) begin
        u_sh  <= {1'b1, tx_data, 1'b0};
        u_n   <= 10;
        u_rdy <= 1'b0;
      end
    end else if (baud_en) begin
      if (u_n == 0) u_rdy <= 1'b1;
      else begin
        u_rx <= {u_sh[0], u_rx[9:1]};
        u_sh <= u_sh >> 1;
        u_n  <= u_n - 1;
        if (u_n == 1) frames.push_back({u_sh[0], u_rx[9:1]});
      end
    end
  end

  // Client drivers
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      logic [N-1:0] f;
      @(posedge clk);
      f = bus.req_valid & bus.req_ready;
      for (int i = 0; i < N; i++)
        if (f[i] && cq[i].size() > 0) void'(cq[i].pop_front());
      #1;
      for (int i = 0; i < N; i++) begin
        if (cq[i].size() > 0 && $urandom_range(99) < vprob) begin
          bus.req_valid[i]       = 1'b1;
          bus.req_data[8*i +: 8] = cq[i][0][7:0];
          bus.req_last[i]        = cq[i][0][8];
        end else begin
          bus.req_valid[i]       = 1'b0;
          bus.req_data[8*i +: 8] = 8'h00;
          bus.req_last[i]        = 1'b0;
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [N-1:0] pv;
    logic [N-1:0] g_prev;
    logic         s_prev;
    logic [9:0]   fr;
    logic [7:0]   e;
    int           w;
    g_prev = '0;
    s_prev = 1'b0;
    forever begin
      @(posedge clk);
      pv = bus.req_valid;
      #2;
      if (mon_en) begin
        if (grant != 0 && g_prev == 0) begin
          w = model_pick(pv, last_owner);
          chk("grant_pick", 32'(grant), (w < 0) ? 32'd0 : 32'd1 << w);
          if (w >= 0) begin
            last_owner = w;
`ifdef UART_ARB_TAG_EN
            expq.push_back(8'h30 + 8'(w));
`endif
            for (int k = 0; k < cq[w].size(); k++) begin
              expq.push_back(cq[w][k][7:0]);
              if (cq[w][k][8]) break;
            end
          end
        end
        if (grant != 0 && g_prev != 0)
          chk("grant_lock", 32'(grant), 32'(g_prev));
        if (bus.req_ready != 0)
          chk("ready_owner", 32'(bus.req_ready & ~grant), 32'd0);
        if (tx_start) begin
          nstart++;
          chk("start_gap", 32'(s_prev), 32'd0);
          chk("start_ready", 32'(tx_ready), 32'd1);
        end
        while (frames.size() > 0) begin
          fr = frames.pop_front();
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_extra: got %0h expected none", fr[8:1]);
          end else begin
            e = expq.pop_front();
            chk("frame_data", 32'(fr[8:1]), 32'(e));
            chk("frame_bits", 32'({fr[9], fr[0]}), 32'd2);
          end
        end
      end
      g_prev = grant;
      s_prev = tx_start;
    end
  end

  task automatic wait_drain(input int budget, input string nm);
    int t;
    t = 0;
    while (!(all_empty() && expq.size() == 0 && grant == 0 && tx_ready)
           && t < budget) begin
      @(posedge clk);
      #3;
      t++;
    end
    checks++;
    if (t >= budget) begin
      errors++;
      $display("FAIL %s: timeout after %0d cycles, pending %0d", nm, t,
               expq.size());
    end
  endtask

  initial begin
    int n0;
    int t;
    // Reset state
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #3;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_start", 32'(tx_start), 32'd0);
      chk("rst_data", 32'(tx_data), 32'd0);
      chk("rst_baud", 32'(baud_en), 32'd0);
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #3;
      chk("baud_en", 32'(baud_en), (k % DIV == 0) ? 32'd1 : 32'd0);
    end
    mon_en = 1'b1;

    // Client 1 two-byte burst
    vprob = 100;
    n0 = nstart;
    cq[1].push_back(9'h041);
    cq[1].push_back(9'h142);
    wait_drain(2000, "burst1_drain");
`ifdef UART_ARB_TAG_EN
    chk("burst1_starts", 32'(nstart - n0), 32'd3);
`else
    chk("burst1_starts", 32'(nstart - n0), 32'd2);
`endif

    // Random contention
    vprob = 70;
    for (int i = 0; i < N; i++)
      for (int b = 0; b < 3; b++) begin
        int len;
        len = $urandom_range(3, 1);
        for (int j = 0; j < len; j++)
          cq[i].push_back({(j == len - 1), 8'($urandom)});
      end
    wait_drain(20000, "random_drain");

    // Reset mid-burst
    vprob = 100;
    cq[3].push_back(9'h011);
    cq[3].push_back(9'h012);
    cq[3].push_back(9'h113);
    t = 0;
    while (!tx_start && t < 200) begin
      @(posedge clk);
      #3;
      t++;
    end
    chk("midrst_start_seen", 32'(tx_start), 32'd1);
    rst = 1'b1;
    mon_en = 1'b0;
    @(posedge clk);
    #3;
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_start", 32'(tx_start), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(bus.req_ready), 32'd0);
    for (int i = 0; i < N; i++) cq[i].delete();
    expq.delete();
    frames.delete();
    bus.req_valid = '0;
    last_owner = N - 1;
    rst = 1'b0;
    mon_en = 1'b1;
    cq[0].push_back(9'h15A);
    t = 0;
    while (grant == 0 && t < 50) begin
      @(posedge clk);
      #3;
      t++;
    end
    chk("post_grant", 32'(grant), 32'd1);
    chk("post_start_c1", 32'(tx_start), 32'd0);
    @(posedge clk);
    #3;
    chk("post_start_c2", 32'(tx_start), 32'd1);
`ifdef UART_ARB_TAG_EN
    chk("post_data", 32'(tx_data), 32'h30);
`else
    chk("post_data", 32'(tx_data), 32'h5A);
`endif
    wait_drain(2000, "post_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
